sr165_reader: RTL



---
 rtl/sr165_reader_if.sv | 38 +++
 rtl/sr165_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sr165_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr165_reader_if
//  Description : Bus bundle between the 74LV165 chain controller and the core.
//                slave  = controller side (sr165_reader)
//                master = core / chain side
//  Signals     : i_start, i_cont, i_ser   core/chain -> controller
//                o_shld, o_serclk         controller -> chain pins
//                o_busy, o_valid, o_data  controller -> core
//                o_changed                only with SR165_CHANGE_DETECT_EN
//  Revision    : 1.0  initial release
// ============================================================================
interface sr165_reader_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic             i_cont;
  logic             i_ser;
  logic             o_shld;
  logic             o_serclk;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
`ifdef SR165_CHANGE_DETECT_EN
  logic             o_changed;

  modport slave  (input  i_start, i_cont, i_ser,
                  output o_shld, o_serclk, o_busy, o_valid, o_data, o_changed);
  modport master (output i_start, i_cont, i_ser,
                  input  o_shld, o_serclk, o_busy, o_valid, o_data, o_changed);
`else
  modport slave  (input  i_start, i_cont, i_ser,
                  output o_shld, o_serclk, o_busy, o_valid, o_data);
  modport master (output i_start, i_cont, i_ser,
                  input  o_shld, o_serclk, o_busy, o_valid, o_data);
`endif
endinterface
`default_nettype wire

// File: rtl/sr165_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sr165_reader
//  Description : Controller for a daisy-chained 74LV165 PISO chain. Drives
//                SH/LD and the serial clock, deserialises the chain output
//                into a WIDTH-bit word and strobes o_valid for one cycle.
//                Frames run on i_start (single shot) or back-to-back while
//                i_cont is high.
//  Parameters  : WIDTH  chain length in bits (1..32)
//                DIV    clk cycles per serial step (>= 1)
//  Ports       : clk    system clock (rising edge)
//                reset  asynchronous active-high reset
//                bus    sr165_reader_if.slave (see interface header)
//  Options     : SR165_CHANGE_DETECT_EN adds bus.o_changed, pulsed with
//                o_valid when the new word differs from the previous one.
//  Revision    : 1.0  initial release
// ============================================================================
module sr165_reader #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic          clk,
  input  logic          reset,
  sr165_reader_if.slave bus
);

  localparam int SW = $clog2(2 * WIDTH + 2);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] C_PRE_MAX   = PW'(DIV - 1);
  localparam logic [SW-1:0] C_LAST_STEP = SW'(2 * WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SETUP    = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_SHIFT_HI = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_pre;
  logic [SW-1:0]    r_step;
  logic [WIDTH-1:0] r_sr;
  logic             r_shld;
  logic             r_serclk;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
`ifdef SR165_CHANGE_DETECT_EN
  logic             r_changed;
`endif

  logic             w_wrap;
  logic             w_timed;
  logic [WIDTH-1:0] w_sr_next;

  assign w_wrap    = (r_pre == C_PRE_MAX);
  // Steps LOAD..SHIFT_HI are paced by the prescaler; IDLE and DONE are not.
  assign w_timed   = (r_state != S_IDLE) && (r_state != S_DONE);
  // Shift left with the new sample in the LSB; written as shift+OR so that
  // WIDTH=1 needs no special case.
  assign w_sr_next = (r_sr << 1) | WIDTH'(bus.i_ser);

  // Outputs are registered from the current state, so each pin waveform
  // trails the state register by one clk. This gives a start-to-valid
  // latency of (2*WIDTH+2)*DIV+1 and a continuous period one cycle longer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pre    <= '0;
      r_step   <= '0;
      r_sr     <= '0;
      r_shld   <= 1'b1;
      r_serclk <= 1'b1;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
`ifdef SR165_CHANGE_DETECT_EN
      r_changed <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef SR165_CHANGE_DETECT_EN
      r_changed <= 1'b0;
`endif
      if (w_timed) begin
        r_pre <= w_wrap ? '0 : r_pre + 1'b1;
        if (w_wrap) begin
          r_step <= r_step + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_shld   <= 1'b1;
          r_serclk <= 1'b1;
          r_busy   <= 1'b0;
          if (bus.i_start | bus.i_cont) begin
            r_state <= S_LOAD;
            r_pre   <= '0;
            r_step  <= '0;
          end
        end
        S_LOAD: begin
          r_shld   <= 1'b0;
          r_serclk <= 1'b1;
          r_busy   <= 1'b1;
          if (w_wrap) r_state <= S_SETUP;
        end
        S_SETUP: begin
          // SH/LD back high for a full step before the first clock edge so
          // QH of the last chip has settled.
          r_shld   <= 1'b1;
          r_serclk <= 1'b1;
          r_busy   <= 1'b1;
          if (w_wrap) r_state <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          r_shld   <= 1'b1;
          r_serclk <= 1'b0;
          r_busy   <= 1'b1;
          // Sample at the end of the low phase, just before the rising edge
          // that moves the chain on.
          if (w_wrap) begin
            r_sr    <= w_sr_next;
            r_state <= S_SHIFT_HI;
          end
        end
        S_SHIFT_HI: begin
          r_shld   <= 1'b1;
          r_serclk <= 1'b1;
          r_busy   <= 1'b1;
          if (w_wrap) begin
            r_state <= (r_step == C_LAST_STEP) ? S_DONE : S_SHIFT_LO;
          end
        end
        S_DONE: begin
          r_shld   <= 1'b1;
          r_serclk <= 1'b1;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_data   <= r_sr;
`ifdef SR165_CHANGE_DETECT_EN
          r_changed <= (r_sr != r_data);
`endif
          r_pre    <= '0;
          r_step   <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_shld   = r_shld;
  assign bus.o_serclk = r_serclk;
  assign bus.o_busy   = r_busy;
  assign bus.o_valid  = r_valid;
  assign bus.o_data   = r_data;
`ifdef SR165_CHANGE_DETECT_EN
  assign bus.o_changed = r_changed;
`endif

endmodule
`default_nettype wire
